// File: rtl/serial_frame_sched.sv
// Round-robin frame scheduler that serializes one parallel word per frame into the
// bit-serial detector and counts detector hits over the frame.
module serial_frame_sched #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] word0,
   input  logic             req1,
   input  logic [WIDTH-1:0] word1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             data,
   output logic             det_en,
   input  logic [2:0]       det_out,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [CNT_W-1:0] hits
);

   // state | meaning
   // IDLE  | waiting for a request; grant issued combinationally here
   // SHIFT | WIDTH cycles driving frame bits MSB-first
   // FLUSH | one cycle catching the detector response to the last bit
   // DONE  | one-cycle completion pulse with requester id
   typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic             last_id;
   logic             det_en_d;
   logic             winner;
   logic             grant;

   always_comb begin
      state_nxt = state;
      winner    = (req0 && req1) ? ~last_id : req1;
      // the reset input is active-high, so grants are held off while it is asserted
      grant     = (state == IDLE) && !rst_n && (req0 || req1);
      gnt0      = grant && !winner;
      gnt1      = grant && winner;
      det_en    = (state == SHIFT);
      data      = det_en && shreg[WIDTH-1];
      busy      = (state != IDLE);
      done      = (state == DONE);
      case (state)
         IDLE:    if (grant) state_nxt = SHIFT;
         SHIFT:   if (bit_cnt == BW'(WIDTH - 1)) state_nxt = FLUSH;
         FLUSH:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         last_id  <= 1'b1;
         det_en_d <= 1'b0;
         hits     <= '0;
         done_id  <= 1'b0;
      end else begin
         state    <= state_nxt;
         det_en_d <= det_en;
         if (grant) begin
            shreg   <= winner ? word1 : word0;
            last_id <= winner;
            bit_cnt <= '0;
         end else if (state == SHIFT) begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + BW'(1);
         end
         if (state == FLUSH)
            done_id <= last_id;
         // detector output lags data by one cycle, hence the delayed enable
         if (grant)
            hits <= '0;
         else if (det_en_d && (det_out != 3'b000) && (hits != {CNT_W{1'b1}}))
            hits <= hits + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_serial_frame_sched.sv
// Bench for serial_frame_sched: directed test-plan steps followed by random traffic,
// all checked against a frame-level reference model.
module tb_serial_frame_sched;

   localparam int W = 8;

   logic       clk;
   logic       rst_n;
   logic       req0, req1;
   logic [W-1:0] word0, word1;
   logic [2:0] det_out;
   logic       gnt0, gnt1, data, det_en, busy, done, done_id;
   logic [3:0] hits;
   logic       gnt0_s, gnt1_s, data_s, det_en_s, busy_s, done_s, done_id_s;
   logic [1:0] hits_s;

   serial_frame_sched #(.WIDTH(W), .CNT_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .word0(word0), .req1(req1), .word1(word1),
      .gnt0(gnt0), .gnt1(gnt1), .data(data), .det_en(det_en), .det_out(det_out),
      .busy(busy), .done(done), .done_id(done_id), .hits(hits));

   serial_frame_sched #(.WIDTH(W), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .req0(req0), .word0(word0), .req1(req1), .word1(word1),
      .gnt0(gnt0_s), .gnt1(gnt1_s), .data(data_s), .det_en(det_en_s), .det_out(det_out),
      .busy(busy_s), .done(done_s), .done_id(done_id_s), .hits(hits_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: a frame is described only by its grant time offset k
   bit       m_act = 0;
   int       m_k = 0;
   logic [W-1:0] m_word = '0;
   bit       m_id = 0;
   bit       m_last = 1;
   int       m_hits = 0;
   bit       m_did = 0;
   bit       g0 = 0, g1 = 0;

   // snapshots of DUT outputs taken at the sample point of the last cycle
   logic s_gnt0, s_gnt1, s_data, s_den, s_busy, s_done, s_did;
   logic [3:0] s_hits;
   logic [1:0] s_hits2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   task automatic cycle(input bit r, input bit q0, input logic [W-1:0] w0,
                        input bit q1, input logic [W-1:0] w1, input logic [2:0] dout);
      bit gn, win, e_den, e_data;
      @(negedge clk);
      rst_n = r; req0 = q0; word0 = w0; req1 = q1; word1 = w1; det_out = dout;
      #1;
      gn     = !r && !m_act && (q0 || q1);
      win    = (q0 && q1) ? !m_last : q1;
      e_den  = m_act && (m_k >= 1) && (m_k <= W);
      e_data = 1'b0;
      if (e_den) e_data = m_word[W - m_k];
      s_gnt0 = gnt0; s_gnt1 = gnt1; s_data = data; s_den = det_en;
      s_busy = busy; s_done = done; s_did = done_id; s_hits = hits; s_hits2 = hits_s;
      chk("gnt0", gnt0, gn && !win);
      chk("gnt1", gnt1, gn && win);
      chk("det_en", det_en, e_den);
      chk("data", data, e_data);
      chk("busy", busy, m_act);
      chk("done", done, m_act && (m_k == W + 2));
      chk("done_id", done_id, m_did);
      chk("hits", hits, sat(m_hits, 15));
      chk("hits_sat", hits_s, sat(m_hits, 3));
      chk("gnt0_sat", gnt0_s, gn && !win);
      chk("done_sat", done_s, m_act && (m_k == W + 2));
      g0 = gn && !win;
      g1 = gn && win;
      @(posedge clk);
      if (r) begin
         m_act = 0; m_k = 0; m_last = 1; m_hits = 0; m_did = 0;
      end else if (m_act) begin
         if ((m_k >= 2) && (m_k <= W + 1) && (dout != 3'b000)) m_hits++;
         if (m_k == W + 1) m_did = m_id;
         if (m_k == W + 2) m_act = 0;
         else m_k++;
      end else if (gn) begin
         m_act = 1; m_k = 1; m_word = win ? w1 : w0; m_id = win; m_last = win; m_hits = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, '0, 3'b000);
   endtask

   initial begin
      int g_at[3];
      int g_id[3];
      int d_id[3];
      int ng, nd, n_den, n_busy;
      logic [W-1:0] dbits;
      bit q0, q1;
      logic [W-1:0] w0, w1;
      logic [2:0] dout;
      bit r;

      rst_n = 1; req0 = 0; req1 = 0; word0 = '0; word1 = '0; det_out = '0;
      repeat (2) @(posedge clk);

      // reset priority: grant suppressed under reset, req0 wins right after release
      cycle(1, 1, 8'h3C, 0, '0, 3'b000);
      cycle(1, 1, 8'h3C, 0, '0, 3'b000);
      chk("rst_gnt0", s_gnt0, 0);
      chk("rst_busy", s_busy, 0);
      cycle(0, 1, 8'h3C, 0, '0, 3'b000);
      chk("rst_rel_gnt0", s_gnt0, 1);
      idle(11);

      // single frame 8'hA5 from requester 0
      cycle(0, 1, 8'hA5, 0, '0, 3'b000);
      chk("sf_gnt0", s_gnt0, 1);
      dbits = '0; n_den = 0; n_busy = 0;
      for (int j = 1; j <= 11; j++) begin
         cycle(0, 0, '0, 0, '0, 3'b000);
         if (s_den) begin dbits = {dbits[W-2:0], s_data}; n_den++; end
         if (s_busy) n_busy++;
         if (j == 10) begin
            chk("sf_done", s_done, 1);
            chk("sf_done_id", s_did, 0);
            chk("sf_hits", s_hits, 0);
         end
      end
      chk("sf_bits", dbits, 8'hA5);
      chk("sf_den_cycles", n_den, 8);
      chk("sf_busy_cycles", n_busy, 10);

      // contention: both requests held from reset release
      cycle(1, 1, 8'h11, 1, 8'h22, 3'b000);
      ng = 0; nd = 0;
      for (int i = 0; i < 33; i++) begin
         cycle(0, 1, 8'h11, 1, 8'h22, 3'b000);
         if ((s_gnt0 || s_gnt1) && ng < 3) begin g_at[ng] = i; g_id[ng] = s_gnt1; ng++; end
         if (s_done && nd < 3) begin d_id[nd] = s_did; nd++; end
      end
      chk("ct_ngrants", ng, 3);
      chk("ct_ndone", nd, 3);
      if (ng == 3) begin
         chk("ct_g0_at", g_at[0], 0);  chk("ct_g0_id", g_id[0], 0);
         chk("ct_g1_at", g_at[1], 11); chk("ct_g1_id", g_id[1], 1);
         chk("ct_g2_at", g_at[2], 22); chk("ct_g2_id", g_id[2], 0);
      end
      if (nd == 3) begin
         chk("ct_d0", d_id[0], 0); chk("ct_d1", d_id[1], 1); chk("ct_d2", d_id[2], 0);
      end
      idle(1);

      // hit count: only offsets 2..W+1 qualify
      for (int j = 0; j <= 10; j++) begin
         dout = (j == 1 || j == 3 || j == 5 || j == 9 || j == 10) ? 3'b001 : 3'b000;
         cycle(0, (j == 0), 8'h5A, 0, '0, dout);
         if (j == 10) begin
            chk("hc_done", s_done, 1);
            chk("hc_hits", s_hits, 3);
         end
      end

      // saturation on the 2-bit counter, then clear by the next grant
      for (int j = 0; j <= 10; j++) begin
         cycle(0, (j == 0), 8'hC3, 0, '0, 3'b110);
         if (j == 10) begin
            chk("sat_hits2", s_hits2, 3);
            chk("sat_hits4", s_hits, 8);
         end
      end
      cycle(0, 1, 8'h0F, 0, '0, 3'b110);
      chk("sat_regrant", s_gnt0, 1);
      chk("sat_hold", s_hits2, 3);
      cycle(0, 0, '0, 0, '0, 3'b110);
      chk("sat_clear", s_hits2, 0);
      idle(10);

      // reset in the middle of SHIFT after the fourth bit
      cycle(0, 1, 8'hF0, 0, '0, 3'b000);
      idle(4);
      cycle(1, 1, 8'hF0, 1, 8'h0F, 3'b000);
      chk("mr_gnt_suppr", s_gnt0 | s_gnt1, 0);
      cycle(0, 1, 8'hF0, 1, 8'h0F, 3'b000);
      chk("mr_data", s_data, 0);
      chk("mr_den", s_den, 0);
      chk("mr_busy", s_busy, 0);
      chk("mr_gnt0", s_gnt0, 1);
      idle(12);

      // random traffic
      q0 = 0; q1 = 0; w0 = '0; w1 = '0;
      for (int i = 0; i < 3000; i++) begin
         if (q0 && g0) begin if ($urandom_range(1) == 0) q0 = 0; end
         else if (q0) begin if ($urandom_range(19) == 0) q0 = 0; end
         else if ($urandom_range(2) == 0) begin q0 = 1; w0 = W'($urandom); end
         if (q1 && g1) begin if ($urandom_range(1) == 0) q1 = 0; end
         else if (q1) begin if ($urandom_range(19) == 0) q1 = 0; end
         else if ($urandom_range(2) == 0) begin q1 = 1; w1 = W'($urandom); end
         r = ($urandom_range(99) == 0);
         dout = ($urandom_range(1) == 0) ? 3'b000 : 3'($urandom_range(7));
         cycle(r, q0, w0, q1, w1, dout);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_frame_sched.md
Name: serial_frame_sched

Overview:
- Round-robin scheduler and serializer that shares the bit-serial detector datapath between two frame requesters.
- Accepts one parallel word per frame.
- Shifts the word into the detector MSB-first, one bit per clock.
- Counts detector hits over the frame and reports a per-frame completion pulse with requester id and hit count.
- Sits between requesters and the detector, driving the detector's serial data input and sampling its 3-bit output.

Parameters:
- WIDTH, 8, frame length in bits (shift cycles per frame); must be ≥ 2.
- CNT_W, 4, width of the hit counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset (1 = reset).
- req0  in  1  requester 0 frame request; held until gnt0.
- word0  in  WIDTH  requester 0 frame data; stable while req0 is high.
- req1  in  1  requester 1 frame request; held until gnt1.
- word1  in  WIDTH  requester 1 frame data; stable while req1 is high.
- gnt0  out  1  one-cycle accept pulse; word0 latched on this edge.
- gnt1  out  1  one-cycle accept pulse; word1 latched on this edge.
- data  out  1  serial bit to the detector.
- det_en  out  1  high while data carries a valid frame bit.
- det_out  in  3  detector output code, registered in the detector (1-cycle latency from data).
- busy  out  1  frame in progress.
- done  out  1  one-cycle end-of-frame pulse.
- done_id  out  1  requester served by the completed frame (0/1).
- hits  out  CNT_W  count of hit cycles in the current/last frame.

Behaviour:
- State machine: IDLE, SHIFT, FLUSH, DONE.
- Reset values: state = IDLE, shift register = 0, bit counter = 0, last_id = 1, det_en_d = 0.
  - All outputs 0: gnt0, gnt1, data, det_en, busy, done, done_id, hits.
- IDLE, granting:
  - If any req is high, the arbiter picks one.
  - gnt of the winner is asserted combinationally in this cycle.
  - On the edge: the word is loaded, last_id := winner, hits := 0, bit counter := 0, state := SHIFT.
  - No req: remain in IDLE.
  - gnt is never asserted outside IDLE or during reset.
- Arbitration:
  - Single request: that requester wins.
  - Both requests: the requester != last_id wins.
  - After reset req0 wins a tie.
- SHIFT:
  - data = shreg[WIDTH-1] and det_en = 1.
  - Each cycle: shift left by 1 (0 fill) and increment the bit counter.
  - After exactly WIDTH SHIFT cycles: state := FLUSH.
- FLUSH (1 cycle):
  - det_en = 0, data = 0.
  - Exists only to capture the detector response to the last bit.
- DONE (1 cycle):
  - done = 1, done_id = last_id; hits holds the final value.
  - Next state IDLE.
- busy = 1 in SHIFT, FLUSH and DONE.
- data = 0 whenever det_en = 0.
- Hit counting:
  - det_en_d is det_en delayed one cycle.
  - In any cycle with det_en_d = 1 and det_out != 3'b000, hits increments by 1.
  - Increment saturates at all-ones with no wrap.
  - det_out is ignored when det_en_d = 0.
  - Exactly WIDTH qualifying cycles per frame.
- hits persistence: hits and done_id hold after DONE until the next grant clears hits.
- Timing, grant at cycle T:
  - Frame bits appear on data at T+1..T+WIDTH.
  - FLUSH at T+WIDTH+1.
  - done at T+WIDTH+2.
  - Earliest next grant at T+WIDTH+3.
- Request held through DONE: the requester is re-granted in the following IDLE cycle, subject to round-robin.
- req deasserted before grant: no frame, no state change.
- Reset mid-frame (any state):
  - Next cycle is IDLE with all reset values, including last_id = 1.
  - Frame abandoned; no done pulse.
  - gnt is suppressed in the reset cycle even if req is high.

Test Plan:
- Reset priority: rst_n=1 for 2 cycles with req0=1 -> no gnt0, all outputs 0; first cycle after release -> gnt0=1.
- Single frame, WIDTH=8, word0=8'hA5, grant at T:
  - data = 1,0,1,0,0,1,0,1 on T+1..T+8, det_en=1 exactly those cycles.
  - busy high T+1..T+10.
  - done=1 at T+10 with done_id=0, hits=0 (det_out=0).
- Contention: req0=req1=1 continuously after reset:
  - gnt0 at T, gnt1 at T+11, gnt0 at T+22.
  - done_id sequence 0,1,0.
- Hit count: det_out=3'b001 at T+3, T+5, T+9 (qualifying) and at T+1, T+10 (non-qualifying) -> hits=3 at done.
- Saturation: CNT_W=2, det_out=3'b110 on all cycles -> hits=3 at done; then next grant -> hits=0.
- Reset mid-SHIFT (after 4th bit): next cycle data=0, det_en=0, busy=0; no done ever; with both reqs high after release -> gnt0 first.
